// File: rtl/enc_pkg.sv
// Shared types and helpers for the encoder velocity path.
package enc_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } vel_state_t;

   // Clamp a 33-bit signed value into the signed range of a w-bit word.
   // The result stays 33 bits wide; callers keep the low w bits.
   function automatic logic signed [CNT_W:0] sat_to_w(input logic signed [CNT_W:0] x,
                                                     input int w);
      logic signed [CNT_W:0] hi;
      logic signed [CNT_W:0] lo;
      hi = (33'sd1 <<< (w - 1)) - 33'sd1;
      lo = -(33'sd1 <<< (w - 1));
      if (x > hi) begin
         return hi;
      end else if (x < lo) begin
         return lo;
      end else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/enc_velocity_iir.sv
// First-order IIR smoother: y += (x - y) >>> FILT_SHIFT, or a direct load.
// Sum stays between old y and x, so truncating back to VEL_W never wraps.
module vel_iir
   import enc_pkg::*;
#(
   parameter int VEL_W      = 16,
   parameter int FILT_SHIFT = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic                    step,
   input  logic signed [VEL_W-1:0] x,
   output logic signed [VEL_W-1:0] y
);

   logic signed [VEL_W:0] x_ext;
   logic signed [VEL_W:0] y_ext;
   logic signed [VEL_W:0] diff;
   logic signed [VEL_W:0] incr;
   logic signed [VEL_W:0] sum;

   // One filter step in VEL_W+1 bits; arithmetic shift floors toward -inf.
   always_comb begin
      x_ext = (VEL_W+1)'(x);
      y_ext = (VEL_W+1)'(y);
      diff  = x_ext - y_ext;
      incr  = diff >>> FILT_SHIFT;
      sum   = y_ext + incr;
   end

   // Filter register; load seeds it with the first sample of a run.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         y <= '0;
      end else if (load) begin
         y <= x;
      end else if (step) begin
         y <= sum[VEL_W-1:0];
      end
   end

endmodule

// File: rtl/enc_velocity.sv
// Windowed velocity from the quadrature position count, with saturation,
// IIR smoothing and a sticky encoder fault latch.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not baselined; waits for enc_ready=1 and sclr=0
// PRIME | captures the baseline count and loads the window counter
// RUN   | window counter runs down; a sample is taken at count 0
module enc_velocity
   import enc_pkg::*;
#(
   parameter int SAMPLE_TICKS = 50000,
   parameter int VEL_W        = 16,
   parameter int FILT_SHIFT   = 3
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    sclr,
   input  logic                    enc_ready,
   input  logic                    enc_error,
   input  logic signed [CNT_W-1:0] enc_count,
   input  logic                    err_clr,
   output logic signed [VEL_W-1:0] vel_raw,
   output logic signed [VEL_W-1:0] vel_flt,
   output logic                    vel_valid,
   output logic                    vel_ok,
   output logic                    fault,
   output logic                    sat
);

   localparam int TICK_W = $clog2(SAMPLE_TICKS);
   localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(SAMPLE_TICKS - 1);

   vel_state_t              state_q;
   vel_state_t              state_d;
   logic [TICK_W-1:0]       tick_cnt;
   logic [CNT_W-1:0]        prev;
   logic                    rebase;
   logic                    sample;
   logic [CNT_W-1:0]        delta_w;
   logic signed [CNT_W:0]   delta;
   logic signed [CNT_W:0]   clipped;
   logic signed [VEL_W-1:0] raw_next;
   logic                    clip_hit;

   assign rebase = sclr || !enc_ready;

   // Modulo-2^32 difference read as signed, so counter wrap gives a small delta.
   always_comb begin
      delta_w  = enc_count - prev;
      delta    = {delta_w[CNT_W-1], delta_w};
      clipped  = sat_to_w(delta, VEL_W);
      raw_next = clipped[VEL_W-1:0];
      clip_hit = (clipped != delta);
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and sample qualifier; a re-baseline always beats the tick.
   always_comb begin
      state_d = state_q;
      sample  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rebase) state_d = PRIME;
         end
         PRIME: begin
            state_d = rebase ? IDLE : RUN;
         end
         RUN: begin
            if (rebase) begin
               state_d = IDLE;
            end else if (tick_cnt == '0) begin
               sample = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Window down-counter and baseline count.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
         prev     <= '0;
      end else if (!rebase) begin
         if (state_q == PRIME || sample) begin
            tick_cnt <= TICK_LOAD;
            prev     <= enc_count;
         end else if (state_q == RUN) begin
            tick_cnt <= tick_cnt - TICK_W'(1);
         end
      end
   end

   // Sample outputs; raw and filtered values hold across a re-baseline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vel_valid <= 1'b0;
         vel_raw   <= '0;
         sat       <= 1'b0;
         vel_ok    <= 1'b0;
      end else begin
         vel_valid <= sample;
         if (sample) begin
            vel_raw <= raw_next;
            sat     <= clip_hit;
            vel_ok  <= 1'b1;
         end else if (rebase) begin
            vel_ok  <= 1'b0;
         end
      end
   end

   // Sticky fault; a fresh error wins over a simultaneous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fault <= 1'b0;
      end else if (enc_error) begin
         fault <= 1'b1;
      end else if (err_clr) begin
         fault <= 1'b0;
      end
   end

   // The first sample after a baseline seeds the filter instead of stepping it.
   vel_iir #(
      .VEL_W      (VEL_W),
      .FILT_SHIFT (FILT_SHIFT)
   ) u_iir (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (sample && !vel_ok),
      .step    (sample && vel_ok),
      .x       (raw_next),
      .y       (vel_flt)
   );

endmodule

// File: tb/tb_enc_velocity.sv
// Bench for enc_velocity with a short window, narrow outputs and light filtering.
module tb_enc_velocity;

   localparam int ST = 10;
   localparam int VW = 8;
   localparam int FS = 2;
   localparam int VMAX = (1 << (VW - 1)) - 1;
   localparam int VMIN = -(1 << (VW - 1));

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               sclr = 1'b0;
   logic               enc_ready = 1'b0;
   logic               enc_error = 1'b0;
   logic               err_clr = 1'b0;
   logic signed [31:0] enc_count = '0;
   logic signed [VW-1:0] vel_raw;
   logic signed [VW-1:0] vel_flt;
   logic               vel_valid;
   logic               vel_ok;
   logic               fault;
   logic               sat;

   int n_checks = 0;
   int n_pass = 0;

   // Reference: run_len counts consecutive cycles with ready=1, sclr=0.
   // The baseline is taken on the 2nd such cycle, a sample every ST after.
   int          run_len;
   logic [31:0] m_base;
   int          m_raw, m_flt;
   bit          m_sat, m_ok, m_valid, m_fault;

   logic [3+2*VW:0] dut_v;
   assign dut_v = {vel_valid, vel_ok, sat, fault, vel_raw, vel_flt};

   enc_velocity #(.SAMPLE_TICKS(ST), .VEL_W(VW), .FILT_SHIFT(FS)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .sclr      (sclr),
      .enc_ready (enc_ready),
      .enc_error (enc_error),
      .enc_count (enc_count),
      .err_clr   (err_clr),
      .vel_raw   (vel_raw),
      .vel_flt   (vel_flt),
      .vel_valid (vel_valid),
      .vel_ok    (vel_ok),
      .fault     (fault),
      .sat       (sat)
   );

   always #5 clock = ~clock;

   function automatic logic [3+2*VW:0] exp_v();
      return {m_valid, m_ok, m_sat, m_fault, VW'(m_raw), VW'(m_flt)};
   endfunction

   task automatic model_reset();
      run_len = 0; m_base = '0; m_raw = 0; m_flt = 0;
      m_sat = 0; m_ok = 0; m_valid = 0; m_fault = 0;
   endtask

   task automatic model_update();
      int d, c;
      if (enc_error) m_fault = 1;
      else if (err_clr) m_fault = 0;
      m_valid = 0;
      if (enc_ready && !sclr) run_len++;
      else begin
         run_len = 0;
         m_ok = 0;
      end
      if (run_len == 2) begin
         m_base = enc_count;
      end else if (run_len >= ST + 2 && (run_len - 2) % ST == 0) begin
         d = $signed(enc_count - m_base);
         c = (d > VMAX) ? VMAX : ((d < VMIN) ? VMIN : d);
         m_sat = (c != d);
         m_flt = m_ok ? m_flt + ((c - m_flt) >>> FS) : c;
         m_raw = c;
         m_ok = 1;
         m_valid = 1;
         m_base = enc_count;
      end
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset_n) model_reset();
      else model_update();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      reset_n = 0;
      step(); step();
      n_checks++;
      if (dut_v !== '0) $display("FAIL reset_outputs: got %h want 0", dut_v); else n_pass++;
      reset_n = 1;
      step();
      n_checks++;
      if (dut_v !== exp_v()) $display("FAIL reset_idle: got %h want %h", dut_v, exp_v()); else n_pass++;
   endtask

   task automatic test_constant_motion();
      int last = -1;
      int nstrobe = 0;
      bit prev_ok = 0;
      enc_ready = 1; sclr = 0; enc_count = 0;
      for (int i = 0; i < 45; i++) begin
         if (i % 2 == 1) enc_count += 3;
         prev_ok = vel_ok;
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL const_cycle%0d: got %h want %h", i, dut_v, exp_v()); else n_pass++;
         if (vel_valid) begin
            nstrobe++;
            n_checks++;
            if (vel_raw !== 8'sd15) $display("FAIL const_raw: got %0d want 15", vel_raw); else n_pass++;
            if (last >= 0) begin
               n_checks++;
               if (i - last != ST) $display("FAIL const_period: got %0d want %0d", i - last, ST); else n_pass++;
            end else begin
               n_checks++;
               if (vel_flt !== 8'sd15 || prev_ok !== 1'b0 || vel_ok !== 1'b1)
                  $display("FAIL const_first: flt %0d ok %b->%b want 15 0->1", vel_flt, prev_ok, vel_ok);
               else n_pass++;
            end
            last = i;
         end
      end
      n_checks++;
      if (nstrobe != 4) $display("FAIL const_count: got %0d strobes want 4", nstrobe); else n_pass++;
   endtask

   task automatic test_wrap();
      bit seen = 0;
      sclr = 1; enc_count = 32'sh7FFFFFF0;
      step();
      sclr = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (i == 5) enc_count = 32'sh80000005;
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL wrap_cycle%0d: got %h want %h", i, dut_v, exp_v()); else n_pass++;
         if (vel_valid) begin
            seen = 1;
            n_checks++;
            if (vel_raw !== 8'sd21 || sat !== 1'b0) $display("FAIL wrap_raw: got %0d sat %b want 21 sat 0", vel_raw, sat);
            else n_pass++;
         end
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL wrap_timeout: got no strobe want one");
      end
   endtask

   task automatic test_saturation();
      int inc_tab[3]   = '{30, -30, 1};
      int every_tab[3] = '{1, 1, 2};
      int raw_tab[3]   = '{127, -128, 5};
      bit sat_tab[3]   = '{1, 1, 0};
      sclr = 1;
      step();
      sclr = 0;
      for (int ph = 0; ph < 3; ph++) begin
         bit seen = 0;
         for (int k = 0; k < 30 && !seen; k++) begin
            if (k % every_tab[ph] == 0) enc_count += inc_tab[ph];
            step();
            n_checks++;
            if (dut_v !== exp_v()) $display("FAIL sat_cycle: got %h want %h", dut_v, exp_v()); else n_pass++;
            if (vel_valid) begin
               seen = 1;
               n_checks++;
               if (vel_raw !== VW'(raw_tab[ph]) || sat !== sat_tab[ph])
                  $display("FAIL sat_phase%0d: got %0d sat %b want %0d sat %b", ph, vel_raw, sat, raw_tab[ph], sat_tab[ph]);
               else n_pass++;
            end
         end
         if (!seen) begin
            n_checks++;
            $display("FAIL sat_timeout%0d: got no strobe want one", ph);
         end
      end
   endtask

   task automatic test_iir_step();
      int flt_tab[4] = '{10, 17, 22, 26};
      int ns = 0;
      sclr = 1;
      step();
      sclr = 0;
      for (int k = 0; k < 100 && ns < 7; k++) begin
         if (ns >= 3) enc_count += 4;
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL iir_cycle: got %h want %h", dut_v, exp_v()); else n_pass++;
         if (vel_valid) begin
            if (ns >= 3) begin
               n_checks++;
               if (vel_flt !== VW'(flt_tab[ns-3]) || vel_raw !== 8'sd40)
                  $display("FAIL iir_flt%0d: got %0d raw %0d want %0d raw 40", ns - 3, vel_flt, vel_raw, flt_tab[ns-3]);
               else n_pass++;
            end
            ns++;
         end
      end
      n_checks++;
      if (ns != 7) $display("FAIL iir_timeout: got %0d strobes want 7", ns); else n_pass++;
   endtask

   task automatic test_rebaseline();
      bit seen = 0;
      bit at_tick = 0;
      for (int k = 0; k < 30 && !at_tick; k++) begin
         if (run_len >= ST + 1 && (run_len - 1) % ST == 0) at_tick = 1;
         else step();
      end
      n_checks++;
      if (!at_tick) $display("FAIL rebase_find: got no tick want one");
      else n_pass++;
      sclr = 1; enc_count += 1000;
      step();
      n_checks++;
      if (vel_valid !== 1'b0 || vel_ok !== 1'b0) $display("FAIL rebase_clear: got valid %b ok %b want 0 0", vel_valid, vel_ok);
      else n_pass++;
      sclr = 0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         enc_count += 2;
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL rebase_cycle%0d: got %h want %h", k, dut_v, exp_v()); else n_pass++;
         if (vel_valid) begin
            seen = 1;
            n_checks++;
            if (k != ST + 2 || vel_raw !== 8'sd20) $display("FAIL rebase_strobe: got cycle %0d raw %0d want cycle %0d raw 20", k, vel_raw, ST + 2);
            else n_pass++;
         end
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL rebase_timeout: got no strobe want one");
      end
   endtask

   task automatic test_fault();
      enc_error = 1;
      step();
      enc_error = 0;
      n_checks++;
      if (fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fault); else n_pass++;
      sclr = 1;
      step(); step();
      n_checks++;
      if (fault !== 1'b1) $display("FAIL fault_sclr: got %b want 1", fault); else n_pass++;
      sclr = 0;
      err_clr = 1; enc_error = 1;
      step();
      n_checks++;
      if (fault !== 1'b1) $display("FAIL fault_both: got %b want 1", fault); else n_pass++;
      enc_error = 0;
      step();
      n_checks++;
      if (fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", fault); else n_pass++;
      err_clr = 0;
      n_checks++;
      if (dut_v !== exp_v()) $display("FAIL fault_model: got %h want %h", dut_v, exp_v()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      enc_error = 1;
      step();
      enc_error = 0;
      for (int k = 0; k < 15; k++) begin
         enc_count += 5;
         step();
      end
      #2 reset_n = 0;
      #1;
      n_checks++;
      if (dut_v !== '0) $display("FAIL reset_mid: got %h want 0", dut_v); else n_pass++;
      model_reset();
      step();
      reset_n = 1;
      for (int k = 1; k <= 20 && !seen; k++) begin
         enc_count += 1;
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL reset_run%0d: got %h want %h", k, dut_v, exp_v()); else n_pass++;
         if (vel_valid) begin
            seen = 1;
            n_checks++;
            if (k != ST + 2 || vel_raw !== 8'sd10) $display("FAIL reset_restart: got cycle %0d raw %0d want cycle %0d raw 10", k, vel_raw, ST + 2);
            else n_pass++;
         end
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL reset_timeout: got no strobe want one");
      end
   endtask

   task automatic test_random();
      int nstrobe = 0;
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 49) == 0) enc_count += int'($urandom);
         else enc_count += int'($urandom_range(0, 80)) - 40;
         sclr      = ($urandom_range(0, 59) == 0);
         enc_ready = ($urandom_range(0, 79) != 0);
         enc_error = ($urandom_range(0, 49) == 0);
         err_clr   = ($urandom_range(0, 29) == 0);
         step();
         n_checks++;
         if (dut_v !== exp_v()) $display("FAIL rand_cycle%0d: got %h want %h", k, dut_v, exp_v()); else n_pass++;
         if (vel_valid) nstrobe++;
      end
      sclr = 0; enc_ready = 1; enc_error = 0; err_clr = 0;
      n_checks++;
      if (nstrobe < 5) $display("FAIL rand_activity: got %0d strobes want >= 5", nstrobe); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_constant_motion();
      test_wrap();
      test_saturation();
      test_iir_step();
      test_rebaseline();
      test_fault();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
